// File: rtl/inference_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : inference_result_packer
//  Purpose  : Takes one frame of NUM_CROPS parallel CNN results and sends them
//             out LSB-first as OUT_WIDTH-bit AXI4-Stream words. The last word
//             is zero-padded, TUSER marks the first word and TLAST the last.
//  Option   : RESULT_PACKER_HEADER_EN - send a header word (frame count at
//             capture, NUM_CROPS) ahead of the payload.
//  Revision : 1.0 - initial release
// ============================================================================
module inference_result_packer #(
    parameter int NUM_CROPS = 5,
    parameter int IN_WIDTH  = 160,
    parameter int OUT_WIDTH = 256,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 ap_rst_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata [NUM_CROPS-1:0],
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 busy
);

    localparam int c_TOTAL_BITS = NUM_CROPS * IN_WIDTH;
    localparam int c_PAY_WORDS  = (c_TOTAL_BITS + OUT_WIDTH - 1) / OUT_WIDTH;
`ifdef RESULT_PACKER_HEADER_EN
    localparam int c_HDR_WORDS  = 1;
`else
    localparam int c_HDR_WORDS  = 0;
`endif
    localparam int c_NUM_WORDS  = c_PAY_WORDS + c_HDR_WORDS;
    localparam int c_BUF_W      = c_NUM_WORDS * OUT_WIDTH;
    localparam int c_IDX_W      = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_BUF_W-1:0]   r_buf;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_s_tready;
    logic                 r_m_tvalid;
    logic                 r_tlast;
    logic                 r_tuser;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_frame_count;

    logic [c_BUF_W-1:0]   w_capture;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic                 w_accept;
    logic                 w_is_last;

    assign w_accept  = r_m_tvalid & m_axis_tready;
    assign w_is_last = (r_idx == c_LAST_IDX);
    assign w_idx_nxt = r_idx + c_IDX_W'(1);

    // Lay the crops out LSB-first behind the optional header; padding stays 0
    always_comb begin
        w_capture = '0;
        for (int k = 0; k < NUM_CROPS; k++) begin
            w_capture[c_HDR_WORDS*OUT_WIDTH + k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata[k];
        end
`ifdef RESULT_PACKER_HEADER_EN
        w_capture[CNT_WIDTH-1:0]   = r_frame_count;
        w_capture[CNT_WIDTH +: 16] = 16'(NUM_CROPS);
`endif
    end

    // Capture/send FSM; the buffer shifts down one word per accepted beat so
    // the current output word always sits in the low OUT_WIDTH bits
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= ST_IDLE;
            r_buf         <= '0;
            r_idx         <= '0;
            r_s_tready    <= 1'b0;
            r_m_tvalid    <= 1'b0;
            r_tlast       <= 1'b0;
            r_tuser       <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s_tready <= 1'b1;
                    r_busy     <= 1'b0;
                    if (r_s_tready && s_axis_tvalid) begin
                        r_buf      <= w_capture;
                        r_idx      <= '0;
                        r_m_tvalid <= 1'b1;
                        r_tuser    <= 1'b1;
                        r_tlast    <= (c_NUM_WORDS == 1);
                        r_s_tready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (w_is_last) begin
                            r_buf         <= '0;
                            r_idx         <= '0;
                            r_m_tvalid    <= 1'b0;
                            r_tlast       <= 1'b0;
                            r_tuser       <= 1'b0;
                            r_s_tready    <= 1'b1;
                            r_busy        <= 1'b0;
                            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
                            r_state       <= ST_IDLE;
                        end else begin
                            r_buf   <= r_buf >> OUT_WIDTH;
                            r_idx   <= w_idx_nxt;
                            r_tuser <= 1'b0;
                            r_tlast <= (w_idx_nxt == c_LAST_IDX);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_buf[OUT_WIDTH-1:0];
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign frame_count   = r_frame_count;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_inference_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inference_result_packer
//  Purpose  : Self-checking bench for inference_result_packer. Expected words
//             come from a bit-level reference: crops are concatenated into one
//             flat vector and bit b lands in word b/OUT, position b%OUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inference_result_packer;

    localparam int NC    = 5;
    localparam int IW    = 160;
    localparam int OW    = 256;
    localparam int CW    = 32;
    localparam int TOTAL = NC * IW;
    localparam int NW    = (TOTAL + OW - 1) / OW;
`ifdef RESULT_PACKER_HEADER_EN
    localparam int HB    = 1;
`else
    localparam int HB    = 0;
`endif
    localparam int NWT   = NW + HB;

    typedef logic [IW-1:0] crops_t [NC-1:0];
    typedef logic [OW-1:0] words_t [NWT];

    logic          clk;
    logic          ap_rst_n;
    logic          s_valid;
    logic          s_axis_tready;
    crops_t        s_data;
    logic          m_axis_tvalid;
    logic          m_ready;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [CW-1:0] frame_count;
    logic          busy;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_fc;

    logic [OW-1:0] rx_data [NWT];
    logic          rx_last [NWT];
    logic          rx_user [NWT];

    inference_result_packer #(
        .NUM_CROPS (NC),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .ap_rst_n      (ap_rst_n),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_data),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_count   (frame_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: flat bit-vector of crops, sliced bit by bit into words
    function automatic void gen_exp(input crops_t c, input logic [CW-1:0] fc, output words_t w);
        logic [TOTAL-1:0] flat;
        for (int i = 0; i < NWT; i++) w[i] = '0;
        for (int k = 0; k < NC; k++) flat[k*IW +: IW] = c[k];
        if (HB == 1) w[0] = OW'({16'(NC), fc});
        for (int b = 0; b < TOTAL; b++) w[HB + b/OW][b%OW] = flat[b];
    endfunction

    function automatic crops_t pat_crops();
        crops_t     c;
        logic [31:0] v;
        for (int k = 0; k < NC; k++) begin
            v    = 32'hC0DE_0000 + 32'(k);
            c[k] = {5{v}};
        end
        return c;
    endfunction

    function automatic crops_t rand_crops();
        crops_t c;
        for (int k = 0; k < NC; k++)
            for (int j = 0; j < IW/32; j++) c[k][j*32 +: 32] = $urandom;
        return c;
    endfunction

    // Present one result set once the packer is ready (bounded wait)
    task automatic send_set(input crops_t c);
        int w = 0;
        while (s_axis_tready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++;
        if (w >= 50) begin
            n_err++;
            $display("FAIL send_wait: s_axis_tready=%b required 1", s_axis_tready);
        end
        s_data  = c;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Drive m_axis_tready at pct% and record accepted words until TLAST
    task automatic collect_frame(input int pct, output int nrx, output int cycles,
                                 output int viol, output int upviol);
        logic [OW-1:0] hd;
        logic          hl, hu, held, done;
        nrx = 0; cycles = 0; viol = 0; upviol = 0; held = 1'b0; done = 1'b0;
        hd = '0; hl = 1'b0; hu = 1'b0;
        while (!done && cycles < 400) begin
            if (held && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd ||
                         m_axis_tlast !== hl || m_axis_tuser !== hu)) viol++;
            if (m_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) upviol++;
            m_ready = ($urandom_range(0, 99) < pct);
            if (m_axis_tvalid === 1'b1 && m_ready) begin
                if (nrx < NWT) begin
                    rx_data[nrx] = m_axis_tdata;
                    rx_last[nrx] = m_axis_tlast;
                    rx_user[nrx] = m_axis_tuser;
                end
                nrx++;
                held = 1'b0;
                if (m_axis_tlast === 1'b1) done = 1'b1;
            end else if (m_axis_tvalid === 1'b1) begin
                held = 1'b1; hd = m_axis_tdata; hl = m_axis_tlast; hu = m_axis_tuser;
            end else begin
                held = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = pat_crops();
        repeat (5) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy} !== 5'b0 ||
                m_axis_tdata !== '0 || frame_count !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b user=%b busy=%b fc=%0d, required all 0",
                         s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_count);
            end
        end
        ap_rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_err++; $display("FAIL post_reset_ready: got %b required 1", s_axis_tready);
        end
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== '0) begin
            n_err++;
            $display("FAIL idle_quiet: got vld=%b busy=%b fc=%0d required 0 0 0", m_axis_tvalid, busy, frame_count);
        end
        m_ready = 1'b0;
        exp_fc  = '0;
    endtask

    task automatic test_single();
        crops_t c; words_t ew; int nrx, cyc, viol, upv;
        c = pat_crops();
        gen_exp(c, exp_fc, ew);
        send_set(c);
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: got vld=%b user=%b busy=%b required 1 1 1", m_axis_tvalid, m_axis_tuser, busy);
        end
        collect_frame(100, nrx, cyc, viol, upv);
        n_cmp++;
        if (nrx !== NWT || cyc !== NWT) begin
            n_err++; $display("FAIL single_count: got words=%0d cycles=%0d required %0d %0d", nrx, cyc, NWT, NWT);
        end
        for (int i = 0; i < NWT; i++) begin
            n_cmp++;
            if (rx_data[i] !== ew[i] || rx_last[i] !== (i == NWT-1) || rx_user[i] !== (i == 0)) begin
                n_err++;
                $display("FAIL single_word%0d: got %h l=%b u=%b required %h l=%b u=%b", i,
                         rx_data[i], rx_last[i], rx_user[i], ew[i], i == NWT-1, i == 0);
            end
        end
        n_cmp++;
        if (rx_data[HB][159:0] !== c[0] || rx_data[HB][255:160] !== c[1][95:0] || rx_data[HB+3][255:32] !== '0) begin
            n_err++;
            $display("FAIL single_layout: got w0=%h w3=%h", rx_data[HB], rx_data[HB+3]);
        end
        exp_fc++;
        n_cmp++;
        if (frame_count !== exp_fc) begin
            n_err++; $display("FAIL single_fc: got %0d required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_backpressure();
        crops_t c; words_t ew; int nrx, cyc, viol, upv;
        for (int f = 0; f < 4; f++) begin
            c = (f == 0) ? pat_crops() : rand_crops();
            gen_exp(c, exp_fc, ew);
            send_set(c);
            collect_frame(50, nrx, cyc, viol, upv);
            n_cmp++;
            if (nrx !== NWT || viol !== 0) begin
                n_err++; $display("FAIL bp_stall f%0d: got words=%0d unstable=%0d required %0d 0", f, nrx, viol, NWT);
            end
            for (int i = 0; i < NWT; i++) begin
                n_cmp++;
                if (rx_data[i] !== ew[i] || rx_last[i] !== (i == NWT-1) || rx_user[i] !== (i == 0)) begin
                    n_err++;
                    $display("FAIL bp_word f%0d w%0d: got %h l=%b u=%b required %h l=%b u=%b", f, i,
                             rx_data[i], rx_last[i], rx_user[i], ew[i], i == NWT-1, i == 0);
                end
            end
            exp_fc++;
            n_cmp++;
            if (frame_count !== exp_fc) begin
                n_err++; $display("FAIL bp_fc f%0d: got %0d required %0d", f, frame_count, exp_fc);
            end
        end
    endtask

    task automatic test_input_during_tx();
        crops_t c1, c2; words_t e1, e2; int nrx, cyc, viol, upv;
        c1 = rand_crops(); c2 = rand_crops();
        gen_exp(c1, exp_fc, e1);
        gen_exp(c2, exp_fc + CW'(1), e2);
        send_set(c1);
        s_data  = c2;
        s_valid = 1'b1;
        collect_frame(100, nrx, cyc, viol, upv);
        n_cmp++;
        if (upv !== 0 || s_axis_tready !== 1'b1) begin
            n_err++; $display("FAIL itx_ready: got early_ready=%0d ready_after=%b required 0 1", upv, s_axis_tready);
        end
        for (int i = 0; i < NWT; i++) begin
            n_cmp++;
            if (nrx !== NWT || rx_data[i] !== e1[i]) begin
                n_err++; $display("FAIL itx_frame1 w%0d: got %h required %h", i, rx_data[i], e1[i]);
            end
        end
        exp_fc++;
        @(posedge clk); #1;
        s_valid = 1'b0;
        n_cmp++;
        if (m_axis_tvalid !== 1'b1) begin
            n_err++; $display("FAIL itx_capture2: got vld=%b required 1", m_axis_tvalid);
        end
        collect_frame(70, nrx, cyc, viol, upv);
        for (int i = 0; i < NWT; i++) begin
            n_cmp++;
            if (nrx !== NWT || rx_data[i] !== e2[i] || rx_last[i] !== (i == NWT-1) || rx_user[i] !== (i == 0)) begin
                n_err++; $display("FAIL itx_frame2 w%0d: got %h required %h", i, rx_data[i], e2[i]);
            end
        end
        exp_fc++;
        n_cmp++;
        if (frame_count !== exp_fc) begin
            n_err++; $display("FAIL itx_fc: got %0d required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_back_to_back();
        crops_t c; words_t ew; int nrx, cyc, viol, upv;
        for (int f = 0; f < 3; f++) begin
            c = rand_crops();
            gen_exp(c, exp_fc, ew);
            send_set(c);
            collect_frame(100, nrx, cyc, viol, upv);
            n_cmp++;
            if (s_axis_tready !== 1'b1 || cyc !== NWT) begin
                n_err++; $display("FAIL b2b_ready f%0d: got rdy=%b cycles=%0d required 1 %0d", f, s_axis_tready, cyc, NWT);
            end
            for (int i = 0; i < NWT; i++) begin
                n_cmp++;
                if (nrx !== NWT || rx_data[i] !== ew[i] || rx_last[i] !== (i == NWT-1) || rx_user[i] !== (i == 0)) begin
                    n_err++; $display("FAIL b2b_word f%0d w%0d: got %h required %h", f, i, rx_data[i], ew[i]);
                end
            end
            exp_fc++;
        end
        n_cmp++;
        if (frame_count !== exp_fc) begin
            n_err++; $display("FAIL b2b_fc: got %0d required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_reset_mid();
        crops_t c; words_t ew; int nrx, cyc, viol, upv;
        send_set(rand_crops());
        m_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ap_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || frame_count !== '0) begin
            n_err++;
            $display("FAIL midreset: got vld=%b last=%b fc=%0d required 0 0 0", m_axis_tvalid, m_axis_tlast, frame_count);
        end
        m_ready = 1'b0;
        exp_fc  = '0;
        repeat (2) @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge clk); #1;
        c = rand_crops();
        gen_exp(c, exp_fc, ew);
        send_set(c);
        collect_frame(60, nrx, cyc, viol, upv);
        for (int i = 0; i < NWT; i++) begin
            n_cmp++;
            if (nrx !== NWT || rx_data[i] !== ew[i] || rx_last[i] !== (i == NWT-1) || rx_user[i] !== (i == 0)) begin
                n_err++; $display("FAIL midreset_next w%0d: got %h u=%b required %h u=%b", i, rx_data[i], rx_user[i], ew[i], i == 0);
            end
        end
        exp_fc++;
        n_cmp++;
        if (frame_count !== exp_fc) begin
            n_err++; $display("FAIL midreset_fc: got %0d required %0d", frame_count, exp_fc);
        end
    endtask

`ifdef RESULT_PACKER_HEADER_EN
    task automatic test_header();
        int nrx, cyc, viol, upv;
        while (exp_fc < CW'(7)) begin
            send_set(rand_crops());
            collect_frame(100, nrx, cyc, viol, upv);
            exp_fc++;
        end
        send_set(pat_crops());
        collect_frame(100, nrx, cyc, viol, upv);
        n_cmp++;
        if (nrx !== 5 || rx_data[0][31:0] !== 32'd7 || rx_data[0][47:32] !== 16'd5 || rx_data[0][255:48] !== '0) begin
            n_err++; $display("FAIL header_word: got n=%0d w0=%h required n=5 fc=7 crops=5", nrx, rx_data[0]);
        end
        n_cmp++;
        if (rx_user[0] !== 1'b1 || rx_user[1] !== 1'b0 || rx_last[4] !== 1'b1 || rx_last[3] !== 1'b0) begin
            n_err++;
            $display("FAIL header_flags: got u0=%b u1=%b l3=%b l4=%b required 1 0 0 1", rx_user[0], rx_user[1], rx_last[3], rx_last[4]);
        end
        exp_fc++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_input_during_tx();
        test_back_to_back();
        test_reset_mid();
`ifdef RESULT_PACKER_HEADER_EN
        test_header();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
